// File: rtl/captura_senha.sv
// Keypad password assembler: buffers digit keys, hands the packed password to the verifier on '#'
// and relays its verdict as a one-cycle result strobe. Optional idle clear via CAPTURA_TIMEOUT_EN.
module captura_senha #(
    parameter int MAX_DIGITS     = 20,
    parameter int MIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                key_valid,
    input  logic [3:0]                          key_code,
    input  logic                                done_in,
    input  logic                                senha_ok_in,
    output logic [4*MAX_DIGITS-1:0]             senha_teste,
    output logic                                valid_out,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_count,
    output logic                                busy,
    output logic                                result_valid,
    output logic                                result_ok,
    output logic                                timeout
);

    localparam int                CNT_W      = $clog2(MAX_DIGITS + 1);
    localparam int                BUF_W      = 4 * MAX_DIGITS;
    localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]  MIN_CNT    = CNT_W'(MIN_DIGITS);
    localparam logic [3:0]        KEY_CLEAR  = 4'hA;
    localparam logic [3:0]        KEY_SUBMIT = 4'hB;
    localparam logic [BUF_W-1:0]  EMPTY_BUF  = {MAX_DIGITS{4'hF}};

    typedef enum logic [1:0] {COLETA, ENVIA, AGUARDA, RESULTADO} state_t;

    state_t state;
    logic   key_accept;
    logic   idle_expired;

    // Codes 0xC-0xF are not keys at all: they neither edit the buffer nor restart the idle timer.
    assign key_accept = key_valid && (key_code <= KEY_SUBMIT);
    assign busy       = (state != COLETA);

`ifdef CAPTURA_TIMEOUT_EN
    localparam int               IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign idle_expired = (state == COLETA) && (digit_count != '0) && !key_accept
                          && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst || state != COLETA || digit_count == '0 || key_accept || idle_expired)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign idle_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLETA;
            senha_teste  <= EMPTY_BUF;
            digit_count  <= '0;
            valid_out    <= 1'b0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                COLETA: begin
                    if (idle_expired) begin
                        senha_teste <= EMPTY_BUF;
                        digit_count <= '0;
                        timeout     <= 1'b1;
                    end else if (key_accept) begin
                        if (key_code <= 4'd9) begin
                            // Full buffer keeps the most recent MAX_DIGITS digits.
                            if (digit_count < MAX_CNT) begin
                                senha_teste[{digit_count, 2'b00} +: 4] <= key_code;
                                digit_count <= digit_count + 1'b1;
                            end else begin
                                senha_teste <= {key_code, senha_teste[BUF_W-1:4]};
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            senha_teste <= EMPTY_BUF;
                            digit_count <= '0;
                        end else if (digit_count >= MIN_CNT) begin
                            state     <= ENVIA;
                            valid_out <= 1'b1;
                        end else begin
                            // Too short to verify: reject locally without bothering the verifier.
                            senha_teste  <= EMPTY_BUF;
                            digit_count  <= '0;
                            result_valid <= 1'b1;
                            result_ok    <= 1'b0;
                        end
                    end
                end
                ENVIA: state <= AGUARDA;
                AGUARDA: begin
                    if (done_in) begin
                        result_ok    <= senha_ok_in;
                        result_valid <= 1'b1;
                        state        <= RESULTADO;
                    end
                end
                RESULTADO: begin
                    senha_teste <= EMPTY_BUF;
                    digit_count <= '0;
                    state       <= COLETA;
                end
                default: state <= COLETA;
            endcase
        end
    end

endmodule
